// File: rtl/dds_pulse_gen_if.sv
// Signal bundle for dds_pulse_gen: phase beats in, config handshake, run control, sample stream out.
// Latency/backpressure are properties of the generator; this file only groups the wires.
// Optional PULSE_EDGE_STROBE_EN adds rise_strobe/fall_strobe to the bundle.
interface dds_pulse_gen_if #(
  parameter int BITWIDTH     = 32,
  parameter int PA_OUT_WIDTH = 14,
  parameter int BURST_WIDTH  = 16
);
  logic                       phase_valid;
  logic [PA_OUT_WIDTH-1:0]    phase_value;
  logic                       cfg_valid;
  logic                       cfg_ready;
  logic [PA_OUT_WIDTH-1:0]    cfg_duty;
  logic [BITWIDTH-2:0]        cfg_amp;
  logic                       cfg_bipolar;
  logic                       cfg_invert;
  logic                       start;
  logic                       stop;
  logic [BURST_WIDTH-1:0]     burst_len;
  logic signed [BITWIDTH-1:0] pulse_out;
  logic                       pulse_valid;
  logic                       pulse_level;
  logic                       wrap;
  logic                       busy;
`ifdef PULSE_EDGE_STROBE_EN
  logic                       rise_strobe;
  logic                       fall_strobe;
`endif

  // Upstream/downstream side: feeds phase, config and control, consumes samples
  modport master (
`ifdef PULSE_EDGE_STROBE_EN
    input  rise_strobe, fall_strobe,
`endif
    output phase_valid, phase_value, cfg_valid, cfg_duty, cfg_amp, cfg_bipolar,
    output cfg_invert, start, stop, burst_len,
    input  cfg_ready, pulse_out, pulse_valid, pulse_level, wrap, busy
  );

  // Generator side
  modport slave (
`ifdef PULSE_EDGE_STROBE_EN
    output rise_strobe, fall_strobe,
`endif
    input  phase_valid, phase_value, cfg_valid, cfg_duty, cfg_amp, cfg_bipolar,
    input  cfg_invert, start, stop, burst_len,
    output cfg_ready, pulse_out, pulse_valid, pulse_level, wrap, busy
  );
endinterface

// File: rtl/dds_pulse_gen.sv
// Square/PWM stage of the DDS chain: phase < duty sets the level, level selects +amp / -amp / 0.
// Latency: 1 cycle from a phase_valid beat to pulse_out/pulse_valid/wrap; outputs hold between beats.
// Backpressure: none on the phase stream; config uses a shadow register, cfg_ready low while a load is pending.
// Optional PULSE_EDGE_STROBE_EN adds rise_strobe/fall_strobe on level changes while running.
module dds_pulse_gen #(
  parameter int BITWIDTH     = 32,
  parameter int PA_OUT_WIDTH = 14,
  parameter int BURST_WIDTH  = 16
) (
  input logic           clk,
  input logic           rst_n,
  dds_pulse_gen_if.slave io
);

  // Reset config reproduces the legacy MSB square wave at full positive scale
  localparam logic [PA_OUT_WIDTH-1:0] DUTY_RST = {1'b1, {(PA_OUT_WIDTH-1){1'b0}}};
  localparam logic [BITWIDTH-2:0]     AMP_RST  = {(BITWIDTH-1){1'b1}};

  typedef enum logic [1:0] {IDLE, ARM, RUN, STOP} state_t;

  state_t                  state;
  logic [BURST_WIDTH-1:0]  cnt;
  logic [BURST_WIDTH-1:0]  blen;
  logic [PA_OUT_WIDTH-1:0] prev_phase;
  logic                    have_prev;

  logic [PA_OUT_WIDTH-1:0] act_duty, sh_duty;
  logic [BITWIDTH-2:0]     act_amp, sh_amp;
  logic                    act_bip, sh_bip;
  logic                    act_inv, sh_inv;
  logic                    pending;

  logic                    wrap_det;
  logic                    load_cfg;
  logic                    use_sh;
  logic [PA_OUT_WIDTH-1:0] eff_duty;
  logic [BITWIDTH-2:0]     eff_amp;
  logic                    eff_bip;
  logic                    eff_inv;
  logic                    lvl;
  logic [BITWIDTH-1:0]     amp_ext;
  logic [BITWIDTH-1:0]     sample;
  logic                    last_period;
  logic                    act_beat;

  // A period starts on the first beat after idle or when the phase word steps backwards
  assign wrap_det = io.phase_valid & (~have_prev | (io.phase_value < prev_phase));

  // Shadow goes live at a period boundary, or immediately when nothing is running
  assign load_cfg = pending & (wrap_det | (state == IDLE));

  // The boundary beat that performs the load already uses the new settings
  assign use_sh   = pending & wrap_det;
  assign eff_duty = use_sh ? sh_duty : act_duty;
  assign eff_amp  = use_sh ? sh_amp  : act_amp;
  assign eff_bip  = use_sh ? sh_bip  : act_bip;
  assign eff_inv  = use_sh ? sh_inv  : act_inv;

  assign lvl     = (io.phase_value < eff_duty) ^ eff_inv;
  assign amp_ext = {1'b0, eff_amp};
  assign sample  = lvl ? amp_ext : (eff_bip ? (~amp_ext + 1'b1) : '0);

  assign io.cfg_ready = ~pending;
  assign io.busy      = (state != IDLE);

  // Decide whether the current beat is emitted as an active sample
  always_comb begin
    last_period = (blen != '0) && (cnt == blen);
    act_beat    = 1'b0;
    case (state)
      ARM:     act_beat = wrap_det & ~io.stop;
      RUN:     act_beat = io.phase_valid & ~(wrap_det & last_period);
      STOP:    act_beat = io.phase_valid & ~wrap_det;
      default: act_beat = 1'b0;
    endcase
  end

  // Run-state sequencing, burst period count and phase history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      blen       <= '0;
      prev_phase <= '0;
      have_prev  <= 1'b0;
    end else begin
      if (io.phase_valid) begin
        prev_phase <= io.phase_value;
        have_prev  <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (io.start) begin
            state <= ARM;
            blen  <= io.burst_len;
            cnt   <= '0;
          end
        end
        ARM: begin
          if (io.stop) begin
            state     <= IDLE;
            have_prev <= 1'b0;
          end else if (wrap_det) begin
            state <= RUN;
            cnt   <= BURST_WIDTH'(1);
          end
        end
        RUN: begin
          if (wrap_det && last_period) begin
            state     <= IDLE;
            have_prev <= 1'b0;
          end else begin
            if (wrap_det && (blen != '0)) cnt <= cnt + 1'b1;
            if (io.stop) state <= STOP;
          end
        end
        STOP: begin
          if (wrap_det) begin
            state     <= IDLE;
            have_prev <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Config shadow capture and period-aligned transfer to the active set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending  <= 1'b0;
      sh_duty  <= '0;
      sh_amp   <= '0;
      sh_bip   <= 1'b0;
      sh_inv   <= 1'b0;
      act_duty <= DUTY_RST;
      act_amp  <= AMP_RST;
      act_bip  <= 1'b0;
      act_inv  <= 1'b1;
    end else if (io.cfg_valid && !pending) begin
      pending <= 1'b1;
      sh_duty <= io.cfg_duty;
      sh_amp  <= io.cfg_amp;
      sh_bip  <= io.cfg_bipolar;
      sh_inv  <= io.cfg_invert;
    end else if (load_cfg) begin
      pending  <= 1'b0;
      act_duty <= sh_duty;
      act_amp  <= sh_amp;
      act_bip  <= sh_bip;
      act_inv  <= sh_inv;
    end
  end

  // Registered sample stream; values only move on valid beats
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      io.pulse_valid <= 1'b0;
      io.pulse_out   <= '0;
      io.pulse_level <= 1'b0;
      io.wrap        <= 1'b0;
    end else begin
      io.pulse_valid <= io.phase_valid;
      if (io.phase_valid) begin
        io.pulse_out   <= act_beat ? sample : '0;
        io.pulse_level <= act_beat & lvl;
        io.wrap        <= wrap_det;
      end
    end
  end

`ifdef PULSE_EDGE_STROBE_EN
  logic running;
  assign running = (state == RUN) || (state == STOP);

  // Level-change strobes between consecutive beats of an established run
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      io.rise_strobe <= 1'b0;
      io.fall_strobe <= 1'b0;
    end else if (io.phase_valid) begin
      io.rise_strobe <= running & act_beat &  lvl & ~io.pulse_level;
      io.fall_strobe <= running & act_beat & ~lvl &  io.pulse_level;
    end
  end
`endif

endmodule

// File: tb/tb_dds_pulse_gen.sv
// Self-checking bench for dds_pulse_gen: a per-beat reference model pushes expected samples,
// a monitor one cycle later pops and compares them, and control/handshake outputs are checked each cycle.
// Covers default square wave, mid-period config, burst, stop, edge configs, start+stop, reset mid-burst.
module tb_dds_pulse_gen;

  localparam int S_IDLE = 0;
  localparam int S_ARM  = 1;
  localparam int S_RUN  = 2;
  localparam int S_STOP = 3;

  typedef struct {
    logic [31:0] out;
    logic        lvl;
    logic        wr;
    logic        rs;
    logic        fs;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  dds_pulse_gen_if #(.BITWIDTH(32), .PA_OUT_WIDTH(14), .BURST_WIDTH(16)) ifc ();

  dds_pulse_gen #(.BITWIDTH(32), .PA_OUT_WIDTH(14), .BURST_WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t sb[$];
  exp_t me;
  logic [31:0] h_out;

  // model state
  int          m_state;
  bit          m_hp;
  logic [13:0] m_prev;
  int          m_per;
  int          m_blen;
  bit          m_pend;
  bit          m_lastlvl;
  logic [13:0] a_duty, s_duty;
  logic [30:0] a_amp, s_amp;
  bit          a_bip, s_bip, a_inv, s_inv;

  // stimulus requests for the next cycle
  bit          cv;
  logic [13:0] c_duty;
  logic [30:0] c_amp;
  bit          c_bip, c_inv;
  logic [15:0] bl;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = S_IDLE; m_hp = 0; m_prev = '0; m_per = 0; m_blen = 0;
    m_pend = 0; m_lastlvl = 0;
    a_duty = 14'd8192; a_amp = 31'h7FFF_FFFF; a_bip = 0; a_inv = 1;
    s_duty = '0; s_amp = '0; s_bip = 0; s_inv = 0;
  endtask

  task automatic offer(input int duty, input int amp, input bit bip, input bit inv);
    cv = 1; c_duty = 14'(duty); c_amp = 31'(amp); c_bip = bip; c_inv = inv;
  endtask

  // One clock: check pre-edge control outputs, drive inputs, advance the model
  task automatic cyc(input bit v, input int ph, input bit st, input bit sp);
    exp_t        e;
    bit          w, lvl, on, use_sh, inv, bip, run_before;
    logic [13:0] p, duty;
    logic [30:0] amp;
    logic [31:0] smp;
    int          nxt;
    @(negedge clk);
    chk("busy", 32'(ifc.busy), 32'(m_state != S_IDLE));
    chk("cfg_ready", 32'(ifc.cfg_ready), 32'(!m_pend));
    p = ph[13:0];
    ifc.phase_valid = v;  ifc.phase_value = p;
    ifc.start = st;       ifc.stop = sp;     ifc.burst_len = bl;
    ifc.cfg_valid = cv;   ifc.cfg_duty = c_duty; ifc.cfg_amp = c_amp;
    ifc.cfg_bipolar = c_bip; ifc.cfg_invert = c_inv;

    w      = v && (!m_hp || (p < m_prev));
    use_sh = m_pend && w;
    duty   = use_sh ? s_duty : a_duty;
    amp    = use_sh ? s_amp  : a_amp;
    bip    = use_sh ? s_bip  : a_bip;
    inv    = use_sh ? s_inv  : a_inv;
    lvl    = (p < duty) != inv;
    if (lvl)      smp = {1'b0, amp};
    else if (bip) smp = 32'd0 - {1'b0, amp};
    else          smp = 32'd0;

    on = 0; nxt = m_state;
    run_before = (m_state == S_RUN) || (m_state == S_STOP);
    case (m_state)
      S_IDLE: if (st) begin nxt = S_ARM; m_blen = int'(bl); end
      S_ARM: begin
        if (sp) nxt = S_IDLE;
        else if (w) begin nxt = S_RUN; on = 1; m_per = 1; end
      end
      S_RUN: begin
        if (w && m_blen != 0 && m_per == m_blen) nxt = S_IDLE;
        else begin
          on = v;
          if (w) m_per++;
          if (sp) nxt = S_STOP;
        end
      end
      default: begin
        if (w) nxt = S_IDLE;
        else on = v;
      end
    endcase

    if (v) begin
      e.out = on ? smp : 32'd0;
      e.lvl = on && lvl;
      e.wr  = w;
      e.rs  = run_before && on && lvl && !m_lastlvl;
      e.fs  = run_before && on && !lvl && m_lastlvl;
      sb.push_back(e);
      m_lastlvl = e.lvl;
      m_prev = p; m_hp = 1;
    end

    if (cv && !m_pend) begin
      s_duty = c_duty; s_amp = c_amp; s_bip = c_bip; s_inv = c_inv; m_pend = 1;
    end else if (m_pend && (w || m_state == S_IDLE)) begin
      a_duty = s_duty; a_amp = s_amp; a_bip = s_bip; a_inv = s_inv; m_pend = 0;
    end

    if (nxt == S_IDLE && m_state != S_IDLE) m_hp = 0;
    m_state = nxt;
    cv = 0;
  endtask

  task automatic ramp(input int from, input int step, input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) cyc(0, 0, 0, 0);
      cyc(1, (from + i * step) % 16384, 0, 0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    ifc.phase_valid = 0; ifc.phase_value = '0; ifc.start = 0; ifc.stop = 0;
    ifc.burst_len = '0; ifc.cfg_valid = 0; ifc.cfg_duty = '0; ifc.cfg_amp = '0;
    ifc.cfg_bipolar = 0; ifc.cfg_invert = 0;
    cv = 0;
    #1;
    chk("rst_out", ifc.pulse_out, 32'd0);
    chk("rst_valid", 32'(ifc.pulse_valid), 32'd0);
    chk("rst_level", 32'(ifc.pulse_level), 32'd0);
    chk("rst_wrap", 32'(ifc.wrap), 32'd0);
    chk("rst_busy", 32'(ifc.busy), 32'd0);
    chk("rst_cfg_ready", 32'(ifc.cfg_ready), 32'd1);
`ifdef PULSE_EDGE_STROBE_EN
    chk("rst_rise", 32'(ifc.rise_strobe), 32'd0);
    chk("rst_fall", 32'(ifc.fall_strobe), 32'd0);
`endif
    model_reset();
    sb.delete();
    h_out = '0;
    @(negedge clk);
    rst_n = 1;
  endtask

  // Output monitor, one step after the active edge
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (sb.size() != 0) begin
        me = sb.pop_front();
        chk("pulse_valid", 32'(ifc.pulse_valid), 32'd1);
        chk("pulse_out", ifc.pulse_out, me.out);
        chk("pulse_level", 32'(ifc.pulse_level), 32'(me.lvl));
        chk("wrap", 32'(ifc.wrap), 32'(me.wr));
`ifdef PULSE_EDGE_STROBE_EN
        chk("rise_strobe", 32'(ifc.rise_strobe), 32'(me.rs));
        chk("fall_strobe", 32'(ifc.fall_strobe), 32'(me.fs));
`endif
        h_out = me.out;
      end else begin
        chk("valid_gap", 32'(ifc.pulse_valid), 32'd0);
        chk("hold_out", ifc.pulse_out, h_out);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_err = 0;
    rst_n = 0; cv = 0; bl = '0; c_duty = '0; c_amp = '0; c_bip = 0; c_inv = 0;
    h_out = '0;
    model_reset();
    do_reset();

    // idle streaming, then continuous default square wave
    ramp(0, 1024, 4, 0);
    bl = 16'd0;
    cyc(0, 0, 1, 0);
    ramp(0, 1024, 32, 0);

    // bipolar config offered mid-period, applied from the next wrap
    ramp(0, 1024, 5, 0);
    offer(4096, 1000, 1, 0);
    cyc(1, 5120, 0, 0);
    ramp(6144, 1024, 10, 0);
    ramp(0, 1024, 32, 1);

    // stop at phase 5000: period completes, idle at next wrap
    for (int i = 0; i < 17; i++) cyc(1, i * 1000, 0, i == 5);
    ramp(0, 1000, 6, 0);

    // 3-period burst started mid-period
    ramp(0, 1024, 6, 0);
    bl = 16'd3;
    cyc(1, 6144, 1, 0);
    ramp(7168, 1024, 9, 0);
    ramp(0, 1024, 16 * 4 + 2, 1);

    // duty=0, invert=0 -> constant 0; then amp=0 bipolar loaded while running
    offer(0, 12345, 0, 0);
    cyc(0, 0, 0, 0);
    bl = 16'd0;
    cyc(0, 0, 1, 0);
    ramp(0, 1024, 20, 0);
    offer(4096, 0, 1, 0);
    cyc(1, 5120, 0, 0);
    ramp(6144, 1024, 26, 0);
    cyc(1, 9216, 0, 1);
    ramp(10240, 1024, 10, 0);

    // strobe-friendly config, continuous with a stop
    offer(8192, 77, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    ramp(0, 1024, 32, 0);
    cyc(1, 0, 0, 1);
    ramp(1024, 1024, 18, 0);

    // start and stop together in IDLE -> ARM; stop in ARM -> IDLE
    cyc(0, 0, 1, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);

    // reset mid-burst with a config pending
    bl = 16'd5;
    cyc(0, 0, 1, 0);
    ramp(0, 1024, 20, 0);
    offer(100, 5, 1, 1);
    cyc(1, 4096, 0, 0);
    cyc(1, 5120, 0, 0);
    do_reset();

    // defaults restored; 2-period burst
    bl = 16'd2;
    cyc(0, 0, 1, 0);
    ramp(0, 1024, 16 * 3 + 2, 0);

    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/dds_pulse_gen.md
Name: dds_pulse_gen

Overview:
- Parametrised square/PWM waveform stage for the DDS chain. Sits after the phase accumulator, in parallel with the other waveform generators.
- Compares the truncated phase word against a programmable duty threshold.
- Drives a signed, amplitude-scaled sample stream with a 1-cycle registered latency.
- Supports a glitch-free shadowed configuration handshake, plus continuous or N-period burst operation with clean period-aligned start and stop.

Parameters:
BITWIDTH, 32, output sample width (two's complement)
PA_OUT_WIDTH, 14, phase word width from the accumulator
BURST_WIDTH, 16, width of the burst period counter

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
phase_valid  input  1  phase_value qualifier, one sample per beat
phase_value  input  PA_OUT_WIDTH  unsigned phase word
cfg_valid  input  1  config offer
cfg_ready  output  1  shadow register free
cfg_duty  input  PA_OUT_WIDTH  high-time threshold: level=1 while phase < duty
cfg_amp  input  BITWIDTH-1  unsigned amplitude magnitude
cfg_bipolar  input  1  1: low level = -amp; 0: low level = 0
cfg_invert  input  1  invert logic level
start  input  1  single-cycle start request
stop  input  1  single-cycle stop request
burst_len  input  BURST_WIDTH  periods per burst, sampled on start; 0 = continuous
pulse_out  output  BITWIDTH  signed sample
pulse_valid  output  1  pulse_out qualifier
pulse_level  output  1  logic level of pulse_out
wrap  output  1  period-start strobe, aligned with pulse_out
busy  output  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0): pulse_out=0, pulse_valid=0, pulse_level=0, wrap=0, busy=0, cfg_ready=1, state=IDLE.
  - Active config resets to duty=2^(PA_OUT_WIDTH-1), amp=2^(BITWIDTH-1)-1, bipolar=0, invert=1. This reproduces the legacy MSB square wave.
  - prev_phase=0, have_prev=0, burst counter=0, shadow pending=0.
  - Reset asserted mid-burst or mid-handshake aborts everything; no state survives.
- Wrap detection, evaluated only on phase_valid beats:
  - wrap_det = !have_prev | (phase_value < prev_phase).
  - prev_phase and have_prev update on every valid beat.
  - have_prev clears on entry to IDLE.
- Config handshake:
  - cfg_valid & cfg_ready captures the cfg_* fields into the shadow register and sets pending; cfg_ready=0 from the next cycle.
  - Shadow copies to active on the first wrap_det beat, or on the next cycle if the state is IDLE.
  - pending clears on that copy; cfg_ready returns to 1 on the following cycle.
  - Result: active config only ever changes at a period boundary while running.
- Level: lvl = (phase_value < duty) ^ invert.
  - duty=0 gives constant low (pre-invert).
  - duty=2^PA_OUT_WIDTH-1 gives high on all phases except all-ones.
- Sample:
  - lvl=1 gives the zero-extended amp.
  - lvl=0 gives -zext(amp) when bipolar, else 0.
  - amp=0 gives 0 for both levels.
- Latency:
  - A valid beat at cycle n produces pulse_out, pulse_level, pulse_valid=1 and wrap=wrap_det at cycle n+1.
  - Outputs hold their value between valid beats; pulse_valid=0 on non-valid cycles.
- IDLE and ARM behaviour:
  - pulse_valid still tracks phase_valid, so downstream keeps streaming.
  - pulse_out=0, pulse_level=0.
  - wrap is still reported.
- FSM:
  - IDLE: on start, latch burst_len into the counter and go to ARM. stop is ignored.
  - ARM: on a wrap_det beat, go to RUN. That beat is output as an active sample and counts as period 1. On stop, go to IDLE.
  - RUN: each subsequent wrap_det beat increments the period count.
    - Burst mode (burst_len != 0): the wrap_det beat that would begin period burst_len+1 goes to IDLE and outputs 0.
    - stop goes to STOP.
    - start is ignored.
  - STOP: the current period completes. The next wrap_det beat goes to IDLE and outputs 0.
- Simultaneous events:
  - start and stop in the same IDLE cycle: start wins.
  - stop and a terminating wrap in the same RUN cycle: go to IDLE.
  - Config load on the same beat as the RUN entry wrap: the new config applies to that beat.
- The phase comparison is unsigned, and the period count width is BURST_WIDTH. No saturation is needed because the count never exceeds burst_len.

Optional Feature:
- Macro PULSE_EDGE_STROBE_EN adds output ports rise_strobe and fall_strobe (1 bit each).
  - A strobe fires with pulse_out when pulse_level changes 0->1 or 1->0 between consecutive valid beats while in RUN or STOP.
  - Strobes are 0 in IDLE and ARM; reset value is 0.
- Without the macro, the ports and their logic are absent.

Test Plan:
- Default after reset, start with burst_len=0, phase ramp 0..16383 step 1024 -> pulse_out=0 for phases <8192 and 0x7FFFFFFF for phases >=8192; wrap=1 on the first active beat; 1-cycle latency.
- cfg: duty=4096, invert=0, bipolar=1, amp=1000, loaded mid-period -> cfg_ready low until the next wrap; from that period, phase<4096 gives 1000 and other phases give -1000 (0xFFFFFC18).
- burst_len=3, start mid-period -> ARM holds output 0 until the wrap; exactly 3 active periods; busy falls at the 4th wrap, which outputs 0.
- Continuous run, stop at phase 5000 -> output continues to end of period; IDLE and pulse_out=0 at the next wrap.
- Edge cases: duty=0 and invert=0 gives constant 0; amp=0 gives all zeros; start+stop in the same cycle gives ARM; rst_n low mid-burst gives all outputs 0 immediately and cfg_ready=1.
- (PULSE_EDGE_STROBE_EN) duty=8192, invert=0, step 1024 -> fall_strobe at phase 8192, rise_strobe at the wrap beat, none in IDLE.
